vslc_scan_sequencer: RTL and testbench

- Control FSM between the SPI EEPROM byte reader and the instruction executor.
- Boots by reading the 4-byte program header, then on each scan cycle:
  - latches the inputs,
  - seeks the reader to the program start,
  - streams bytes start..end to the executor through a 2-deep skid buffer with valid/ready.
- Replaces the ad-hoc restart/header logic in the core top level.
- Adds trigger arbitration, backpressure via EEPROM HOLD, a watchdog and error reporting.

---
 rtl/vslc_seq_pkg.sv | 13 +
 rtl/vslc_skid_buf2.sv | 32 +++
 rtl/vslc_scan_sequencer.sv | 139 +++++++++++++
 tb/tb_vslc_scan_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vslc_seq_pkg.sv
// vslc_seq_pkg: shared states, error codes and header layout for the scan sequencer
package vslc_seq_pkg;
    typedef enum logic [2:0] {BOOT, HDR, ARM, SEEK, RUN, DONE, ERR} state_t;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_HDR = 2'd1;
    localparam logic [1:0] ERR_WDOG    = 2'd2;
    localparam logic [1:0] ERR_OVF     = 2'd3;
    localparam logic [15:0] HDR_START_HI = 16'd0;
    localparam logic [15:0] HDR_START_LO = 16'd1;
    localparam logic [15:0] HDR_END_HI   = 16'd2;
    localparam logic [15:0] HDR_END_LO   = 16'd3;
    localparam int HDR_BYTES = 4;
endpackage

// File: rtl/vslc_skid_buf2.sv
// vslc_skid_buf2: 2-entry FIFO skid buffer with valid/ready output and overflow flag
module vslc_skid_buf2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       empty,
    output logic       overflow
);
    logic [7:0] d0, d1;
    logic [1:0] cnt;
    logic       full, pop, acc;
    assign empty     = cnt == 2'd0;
    assign full      = cnt == 2'd2;
    assign out_valid = !empty;
    assign out_data  = d0;
    assign pop       = out_valid && out_ready;
    assign acc       = in_valid && (!full || pop);
    assign overflow  = in_valid && full && !pop;
    // head lives in d0; d1 only holds the second entry
    always_ff @(posedge clk) begin
        if (rst || flush) cnt <= 2'd0;
        else cnt <= cnt + 2'(acc) - 2'(pop);
        if (pop) d0 <= full ? d1 : in_data;
        else if (acc && empty) d0 <= in_data;
        if (acc && (full || (cnt == 2'd1 && !pop))) d1 <= in_data;
    end
endmodule

// File: rtl/vslc_scan_sequencer.sv
// vslc_scan_sequencer: boots from the EEPROM header and streams each scan's program bytes to the executor
module vslc_scan_sequencer
    import vslc_seq_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WDOG_CYCLES = 4096,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_valid,
    input  logic [7:0]       rd_data,
    input  logic [15:0]      rd_addr,
    output logic             rd_restart,
    output logic [15:0]      rd_start_addr,
    output logic             rd_hold_n,
    output logic             instr_valid,
    output logic [7:0]       instr_data,
    input  logic             ex_ready,
    input  logic             auto_mode,
    input  logic             trig_in,
    output logic             inputs_latch,
    output logic             scan_active,
    output logic             scan_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    state_t state, state_n;
    logic [ADDR_W-1:0] start_a, end_a;
    logic [WD_W-1:0]   wd;
    logic [2:0]        trig_s;
    logic [1:0]        err_n;
    logic hdr_done, end_seen, trig_pend;
    logic push, in_range, hdr_ok, go, wd_hit;
    logic b_valid, b_empty, b_ovf;
    assign in_range      = rd_addr >= 16'(start_a) && rd_addr <= 16'(end_a);
    assign push          = state == RUN && rd_valid && in_range;
    assign hdr_ok        = start_a >= ADDR_W'(HDR_BYTES) && end_a != '0 && end_a >= start_a;
    assign go            = auto_mode || trig_pend;
    assign wd_hit        = (state == HDR || state == RUN) && rd_hold_n && !rd_valid && wd == WD_W'(WDOG_CYCLES - 1);
    assign rd_restart    = !rst && (state == BOOT || state == SEEK);
    assign rd_start_addr = state == SEEK ? 16'(start_a) : 16'd0;
    assign rd_hold_n     = state == ERR || ex_ready || b_empty;
    assign instr_valid   = b_valid && state != ERR;
    assign inputs_latch  = state == ARM && go;
    assign scan_active   = state == SEEK || state == RUN;
    assign scan_done     = state == DONE;
    assign err           = state == ERR;
    vslc_skid_buf2 u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (state == ERR),
        .in_valid  (push),
        .in_data   (rd_data),
        .out_ready (ex_ready),
        .out_valid (b_valid),
        .out_data  (instr_data),
        .empty     (b_empty),
        .overflow  (b_ovf)
    );
    // next state; buffer overflow outranks watchdog outranks header check
    always_comb begin
        state_n = state;
        err_n   = ERR_NONE;
        case (state)
            BOOT: state_n = HDR;
            HDR: if (hdr_done) begin
                state_n = hdr_ok ? ARM : ERR;
                err_n   = hdr_ok ? ERR_NONE : ERR_BAD_HDR;
            end
            ARM:  state_n = go ? SEEK : ARM;
            SEEK: state_n = RUN;
            RUN:  state_n = end_seen && b_empty ? DONE : RUN;
            DONE: state_n = ARM;
            default: state_n = ERR;
        endcase
        if (wd_hit) begin
            state_n = ERR;
            err_n   = ERR_WDOG;
        end
        if (b_ovf) begin
            state_n = ERR;
            err_n   = ERR_OVF;
        end
    end
    // state register, scan counter and the error code latched on ERR entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            cycle_count <= '0;
            err_code    <= ERR_NONE;
        end else begin
            state <= state_n;
            if (state == DONE) cycle_count <= cycle_count + 1'b1;
            if (state != ERR && state_n == ERR) err_code <= err_n;
        end
    end
    // header capture keyed by EEPROM address; validated the cycle after the last byte
    always_ff @(posedge clk) begin
        if (rst) begin
            start_a  <= '0;
            end_a    <= '0;
            hdr_done <= 1'b0;
        end else if (state == HDR && rd_valid && !hdr_done) begin
            case (rd_addr)
                HDR_START_HI: start_a[ADDR_W-1:8] <= rd_data[ADDR_W-9:0];
                HDR_START_LO: start_a[7:0] <= rd_data;
                HDR_END_HI:   end_a[ADDR_W-1:8] <= rd_data[ADDR_W-9:0];
                HDR_END_LO: begin
                    end_a[7:0] <= rd_data;
                    hdr_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
    // remember that the last program byte entered the buffer this scan
    always_ff @(posedge clk) begin
        if (rst || state == SEEK) end_seen <= 1'b0;
        else if (push && !b_ovf && rd_addr == 16'(end_a)) end_seen <= 1'b1;
    end
    // trigger synchronizer and one-deep pending flag; a new edge wins over consumption
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s    <= 3'b000;
            trig_pend <= 1'b0;
        end else begin
            trig_s    <= {trig_s[1:0], trig_in};
            trig_pend <= (trig_s[1] && !trig_s[2]) || (trig_pend && !inputs_latch);
        end
    end
    // watchdog counts idle cycles in HDR/RUN; held at zero while the reader is paused
    always_ff @(posedge clk) begin
        if (rst || rd_valid || state_n != state || !rd_hold_n) wd <= '0;
        else if (state == HDR || state == RUN) wd <= wd + 1'b1;
    end
endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// tb_vslc_scan_sequencer: header table, scan scoreboard and multi-cycle corner cases
module tb_vslc_scan_sequencer;
    logic        clk, rst, rd_valid, rd_restart, rd_hold_n, instr_valid, ex_ready;
    logic        auto_mode, trig_in, inputs_latch, scan_active, scan_done, err;
    logic [7:0]  rd_data, instr_data;
    logic [15:0] rd_addr, rd_start_addr, cycle_count;
    logic [1:0]  err_code;

    vslc_scan_sequencer dut (
        .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr),
        .rd_restart(rd_restart), .rd_start_addr(rd_start_addr), .rd_hold_n(rd_hold_n),
        .instr_valid(instr_valid), .instr_data(instr_data), .ex_ready(ex_ready),
        .auto_mode(auto_mode), .trig_in(trig_in), .inputs_latch(inputs_latch),
        .scan_active(scan_active), .scan_done(scan_done), .cycle_count(cycle_count),
        .err(err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s;
        int e;
        int code;
    } hdr_vec_t;

    logic [7:0] mem [0:1023];
    logic [7:0] sb [$];
    int n_cmp, n_bad, cyc, latch_cyc, hs, he;
    int n_restart, n_scan, n_latch, n_done, n_xfer, n_sent, rdr_ptr;
    bit rdr_en, rdr_on, rdr_ign, rdr_hold_s, found;
    logic [15:0] last_rs;
    hdr_vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: observe outputs at negedge, then drive the reader model after posedge
    task automatic step();
        logic [7:0] exp_b;
        @(negedge clk);
        cyc++;
        if (instr_valid && ex_ready) begin
            n_xfer++;
            if (sb.size() == 0) chk("sb_unexpected_byte", int'(instr_data), -1);
            else begin
                exp_b = sb.pop_front();
                chk("sb_instr_data", int'(instr_data), int'(exp_b));
            end
        end
        if (inputs_latch) begin
            n_latch++;
            latch_cyc = cyc;
        end
        if (rd_restart) begin
            n_restart++;
            last_rs = rd_start_addr;
            rdr_ptr = int'(rd_start_addr);
            rdr_on  = 1'b1;
            n_sent  = 0;
            if (rd_start_addr != 16'd0) begin
                n_scan++;
                chk("latch_to_restart", cyc - latch_cyc, 1);
                for (int a = hs; a <= he; a++) sb.push_back(mem[a]);
            end
        end
        if (scan_done) begin
            n_done++;
            chk("drained_at_done", sb.size(), 0);
        end
        rdr_hold_s = rd_hold_n;
        @(posedge clk);
        #1;
        if (rdr_en && rdr_on && (rdr_hold_s || rdr_ign) && rdr_ptr < 1024) begin
            rd_valid = 1'b1;
            rd_addr  = 16'(rdr_ptr);
            rd_data  = mem[rdr_ptr];
            rdr_ptr++;
            n_sent++;
        end else rd_valid = 1'b0;
    endtask

    task automatic load_hdr(input int s, input int e);
        mem[0] = 8'(s >> 8);
        mem[1] = 8'(s);
        mem[2] = 8'(e >> 8);
        mem[3] = 8'(e);
        hs = s;
        he = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_valid = 1'b0;
        trig_in = 1'b0;
        rdr_on = 1'b0;
        rdr_en = 1'b1;
        rdr_ign = 1'b0;
        sb.delete();
        step();
        step();
        chk("rst_rd_restart", int'(rd_restart), 0);
        chk("rst_rd_hold_n", int'(rd_hold_n), 1);
        chk("rst_instr_valid", int'(instr_valid), 0);
        chk("rst_cycle_count", int'(cycle_count), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_scan_active", int'(scan_active), 0);
        chk("rst_pulses", int'({scan_done, inputs_latch}), 0);
        n_restart = 0; n_scan = 0; n_latch = 0; n_done = 0; n_xfer = 0;
        rst = 1'b0;
    endtask

    task automatic run_until_done(input int target, input int budget);
        for (int i = 0; i < budget && n_done < target; i++) step();
        chk("done_reached", n_done, target);
    endtask

    task automatic wait_scans(input int target, input int budget);
        for (int i = 0; i < budget && n_scan < target; i++) step();
        chk("scan_restart_reached", n_scan, target);
    endtask

    task automatic pulse_trig();
        trig_in = 1'b1;
        repeat (3) step();
        trig_in = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        tbl[0] = '{4, 7, 0};
        tbl[1] = '{4, 3, 1};
        tbl[2] = '{3, 7, 1};
        tbl[3] = '{4, 0, 1};
        tbl[4] = '{4, 4, 0};
        tbl[5] = '{10'h1F0, 10'h3FF, 0};
        tbl[6] = '{10'h200, 10'h1FF, 1};
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 13 + 5);
        n_cmp = 0; n_bad = 0; cyc = 0; latch_cyc = 0;
        rst = 1'b1; rd_valid = 1'b0; rd_data = 8'd0; rd_addr = 16'd0;
        ex_ready = 1'b1; auto_mode = 1'b0; trig_in = 1'b0;

        // header validation table; ARM waits without a trigger, ERR is terminal
        for (int t = 0; t < 7; t++) begin
            load_hdr(tbl[t].s, tbl[t].e);
            auto_mode = 1'b0;
            do_reset();
            chk("hdr_err_after_rst", int'(err), 0);
            repeat (30) step();
            chk("hdr_err", int'(err), int'(tbl[t].code != 0));
            chk("hdr_err_code", int'(err_code), tbl[t].code);
            chk("hdr_restarts", n_restart, 1);
            chk("hdr_no_latch", n_latch, 0);
        end

        // free-running scans of bytes 4..7
        load_hdr(4, 7);
        auto_mode = 1'b1;
        ex_ready = 1'b1;
        do_reset();
        run_until_done(1, 100);
        chk("auto_cycle_count1", int'(cycle_count), 1);
        chk("auto_latch1", n_latch, 1);
        chk("auto_restart_addr", int'(last_rs), 4);
        chk("auto_xfer1", n_xfer, 4);
        run_until_done(2, 100);
        chk("auto_cycle_count2", int'(cycle_count), 2);
        chk("auto_xfer2", n_xfer, 8);

        // triggered scans; three edges during RUN merge into one pending scan
        load_hdr(4, 64);
        auto_mode = 1'b0;
        do_reset();
        repeat (50) step();
        chk("trig_idle_latch", n_latch, 0);
        chk("trig_idle_done", n_done, 0);
        pulse_trig();
        run_until_done(1, 300);
        repeat (100) step();
        chk("trig_one_scan", n_done, 1);
        chk("trig_one_latch", n_latch, 1);
        pulse_trig();
        wait_scans(2, 100);
        repeat (5) step();
        chk("trig_in_run", int'(scan_active), 1);
        pulse_trig();
        pulse_trig();
        pulse_trig();
        run_until_done(3, 400);
        repeat (150) step();
        chk("trig_merge_done", n_done, 3);
        chk("trig_merge_count", int'(cycle_count), 3);
        chk("trig_merge_latch", n_latch, 3);

        // backpressure: hold drops after first push, one in-flight byte absorbed
        auto_mode = 1'b1;
        ex_ready = 1'b0;
        do_reset();
        wait_scans(1, 100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (instr_valid) found = 1'b1;
        end
        chk("bp_first_push", int'(found), 1);
        chk("bp_hold_fall", int'(rd_hold_n), 0);
        repeat (4) step();
        chk("bp_sent_two", n_sent, 2);
        chk("bp_no_err", int'(err), 0);
        chk("bp_hold_low", int'(rd_hold_n), 0);
        ex_ready = 1'b1;
        step();
        chk("bp_hold_rise", int'(rd_hold_n), 1);
        run_until_done(1, 300);
        chk("bp_xfer_all", n_xfer, 61);
        chk("bp_no_err_end", int'(err), 0);

        // watchdog after the reader goes silent in RUN
        do_reset();
        wait_scans(1, 100);
        repeat (3) step();
        rdr_en = 1'b0;
        found = 1'b0;
        begin
            int wd_t;
            wd_t = 0;
            for (int i = 1; i <= 4200 && !found; i++) begin
                step();
                if (err) begin
                    found = 1'b1;
                    wd_t = i;
                end
            end
            chk("wdog_fired", int'(found), 1);
            chk("wdog_timing", int'(wd_t >= 4096 && wd_t <= 4098), 1);
        end
        chk("wdog_code", int'(err_code), 2);
        chk("wdog_instr_valid", int'(instr_valid), 0);
        chk("wdog_hold_n", int'(rd_hold_n), 1);

        // reader ignoring HOLD overflows the buffer
        ex_ready = 1'b0;
        do_reset();
        wait_scans(1, 100);
        rdr_ign = 1'b1;
        repeat (6) step();
        chk("ovf_err", int'(err), 1);
        chk("ovf_code", int'(err_code), 3);
        chk("ovf_instr_valid", int'(instr_valid), 0);
        begin
            int r0;
            r0 = n_restart;
            repeat (10) step();
            chk("ovf_no_restart", n_restart, r0);
        end

        // reset in the middle of a scan with a byte buffered
        ex_ready = 1'b1;
        do_reset();
        run_until_done(1, 300);
        ex_ready = 1'b0;
        wait_scans(2, 100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (instr_valid) found = 1'b1;
        end
        chk("mid_buffered", int'(found), 1);
        rst = 1'b1;
        sb.delete();
        step();
        chk("mid_instr_valid", int'(instr_valid), 0);
        chk("mid_cycle_count", int'(cycle_count), 0);
        rst = 1'b0;
        n_restart = 0;
        step();
        chk("mid_boot_restart", n_restart, 1);
        chk("mid_boot_addr", int'(last_rs), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
